// File: rtl/uart_triple_buffer_top.sv
// UART loopback through three external async SRAMs used as a triple buffer.
// RX bytes fill the WRITE bank; full buffers rotate to READ and are retransmitted.
module uart_triple_buffer_top #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned BUF_DEPTH    = 16,
    parameter int unsigned SRAM_WAIT    = 2
) (
    input  logic        clk_in,
    input  logic        button_reset,
    input  logic        uart_in,
    input  logic        tx_flow_control,
    output logic        uart_out,
    output logic [15:0] sram_x_addr,
    output logic        sram_x_we_n,
    output logic        sram_x_oe_n,
    output logic        sram_x_ce_a_n,
    output logic        sram_x_ub_a_n,
    output logic        sram_x_lb_a_n,
    inout  wire  [15:0] sram_x_data_io,
    output logic [15:0] sram_y_addr,
    output logic        sram_y_we_n,
    output logic        sram_y_oe_n,
    output logic        sram_y_ce_a_n,
    output logic        sram_y_ub_a_n,
    output logic        sram_y_lb_a_n,
    inout  wire  [15:0] sram_y_data_io,
    output logic [15:0] sram_z_addr,
    output logic        sram_z_we_n,
    output logic        sram_z_oe_n,
    output logic        sram_z_ce_a_n,
    output logic        sram_z_ub_a_n,
    output logic        sram_z_lb_a_n,
    inout  wire  [15:0] sram_z_data_io
);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned SW = $clog2(SRAM_WAIT + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(SRAM_WAIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wr_state_e;
    typedef enum logic [1:0] {T_IDLE, T_READ, T_SEND} tx_state_e;

    rx_state_e r_rx_st, w_rx_nxt;
    wr_state_e r_wr_st, w_wr_nxt;
    tx_state_e r_tx_st, w_tx_nxt;

    logic [2:0]    r_rx_sync;
    logic [CW-1:0] r_rcnt, r_tcnt;
    logic [2:0]    r_rbit;
    logic [7:0]    r_rshift, r_hold_data, r_wbyte;
    logic          r_hold_valid;
    logic [SW-1:0] r_wcnt, r_scnt;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [1:0]    r_bank_wr, r_bank_rdy, r_bank_rd;
    logic          r_rdy_full, r_rd_full;
    logic [8:0]    r_tshift;
    logic [3:0]    r_tbit;
    logic          r_uart;
    logic [2:0]    r_we_n, r_oe_n, r_ce_n, r_doe;
    logic [2:0][15:0] r_addr, r_dout;

    logic       w_rx, w_rx_fall, w_rx_tick, w_wr_start, w_wswap, w_rswap;
    logic       w_rd_latch, w_tx_tick;
    logic [7:0] w_wbyte, w_rd_byte;
    logic [2:0] w_sel_wr, w_sel_rd;

    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_tick = (r_rx_st == R_START && r_rcnt == HALF_LAST) ||
                       ((r_rx_st == R_DATA || r_rx_st == R_STOP) && r_rcnt == BIT_LAST);
    assign w_wr_start = (r_wr_st == W_IDLE) && r_hold_valid;
    assign w_wbyte    = w_wr_start ? r_hold_data : r_wbyte;
    // Write-swap has priority; a pending read-swap simply happens a cycle later.
    assign w_wswap    = (r_wr_st == W_HOLD) && (r_wr_ptr == PTR_LAST);
    assign w_rswap    = !r_rd_full && r_rdy_full && !w_wswap;
    assign w_rd_latch = (r_tx_st == T_READ) && (r_scnt == WAIT_LAST);
    assign w_tx_tick  = (r_tx_st == T_SEND) && (r_tcnt == BIT_LAST);

    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_rx_st <= R_IDLE;
            r_wr_st <= W_IDLE;
            r_tx_st <= T_IDLE;
        end else begin
            r_rx_st <= w_rx_nxt;
            r_wr_st <= w_wr_nxt;
            r_tx_st <= w_tx_nxt;
        end
    end

    always_comb begin
        w_rx_nxt = r_rx_st;
        w_wr_nxt = r_wr_st;
        w_tx_nxt = r_tx_st;
        case (r_rx_st)
            R_IDLE:  if (w_rx_fall) w_rx_nxt = R_START;
            R_START: if (w_rx_tick) w_rx_nxt = w_rx ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_tick && r_rbit == 3'd7) w_rx_nxt = R_STOP;
            R_STOP:  if (w_rx_tick) w_rx_nxt = R_IDLE;
            default: w_rx_nxt = R_IDLE;
        endcase
        case (r_wr_st)
            W_IDLE:   if (r_hold_valid) w_wr_nxt = W_SETUP;
            W_SETUP:  w_wr_nxt = W_STROBE;
            W_STROBE: if (r_wcnt == WAIT_LAST) w_wr_nxt = W_HOLD;
            W_HOLD:   w_wr_nxt = W_IDLE;
            default:  w_wr_nxt = W_IDLE;
        endcase
        case (r_tx_st)
            T_IDLE:  if (r_rd_full && !tx_flow_control) w_tx_nxt = T_READ;
            T_READ:  if (w_rd_latch) w_tx_nxt = T_SEND;
            T_SEND:  if (w_tx_tick && r_tbit == 4'd9) w_tx_nxt = T_IDLE;
            default: w_tx_nxt = T_IDLE;
        endcase
    end

    // Receive datapath and single-entry holding register
    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_rx_sync    <= 3'b111;
            r_rcnt       <= '0;
            r_rbit       <= '0;
            r_rshift     <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], uart_in};
            r_rcnt    <= (r_rx_st == R_IDLE || w_rx_tick) ? CW'(0) : r_rcnt + CW'(1);
            if (r_rx_st == R_START) r_rbit <= 3'd0;
            if (r_rx_st == R_DATA && w_rx_tick) begin
                r_rshift <= {w_rx, r_rshift[7:1]};
                r_rbit   <= r_rbit + 3'd1;
            end
            if (r_rx_st == R_STOP && w_rx_tick && w_rx) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= r_rshift;
            end else if (w_wr_start) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Write sequencing, bank rotation and transmit datapath
    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_wcnt     <= '0;
            r_wbyte    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_bank_wr  <= 2'd0;
            r_bank_rdy <= 2'd1;
            r_bank_rd  <= 2'd2;
            r_rdy_full <= 1'b0;
            r_rd_full  <= 1'b0;
            r_scnt     <= '0;
            r_tcnt     <= '0;
            r_tshift   <= '1;
            r_tbit     <= '0;
            r_uart     <= 1'b1;
        end else begin
            r_wcnt <= (r_wr_st == W_STROBE) ? r_wcnt + SW'(1) : SW'(0);
            if (w_wr_start) r_wbyte <= r_hold_data;
            if (r_wr_st == W_HOLD) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_wswap) begin
                r_bank_wr  <= r_bank_rdy;
                r_bank_rdy <= r_bank_wr;
                r_rdy_full <= 1'b1;
            end else if (w_rswap) begin
                r_bank_rd  <= r_bank_rdy;
                r_bank_rdy <= r_bank_rd;
                r_rdy_full <= 1'b0;
            end
            if (w_rswap) r_rd_full <= 1'b1;
            else if (w_rd_latch && r_rd_ptr == PTR_LAST) r_rd_full <= 1'b0;
            r_scnt <= (r_tx_st == T_READ) ? r_scnt + SW'(1) : SW'(0);
            r_tcnt <= (r_tx_st == T_SEND && !w_tx_tick) ? r_tcnt + CW'(1) : CW'(0);
            if (w_rswap) r_rd_ptr <= '0;
            else if (w_rd_latch) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_rd_latch) begin
                r_tshift <= {1'b1, w_rd_byte};
                r_tbit   <= 4'd0;
                r_uart   <= 1'b0;
            end else if (w_tx_tick) begin
                r_uart   <= r_tshift[0];
                r_tshift <= {1'b1, r_tshift[8:1]};
                r_tbit   <= r_tbit + 4'd1;
            end
        end
    end

    always_comb begin
        case (r_bank_rd)
            2'd0:    w_rd_byte = sram_x_data_io[7:0];
            2'd1:    w_rd_byte = sram_y_data_io[7:0];
            default: w_rd_byte = sram_z_data_io[7:0];
        endcase
        for (int b = 0; b < 3; b++) begin
            w_sel_wr[b] = (w_wr_nxt != W_IDLE) && (r_bank_wr == 2'(b));
            w_sel_rd[b] = (w_tx_nxt == T_READ) && (r_bank_rd == 2'(b));
        end
    end

    // Per-bank strobes registered from next state so pins are glitch-free
    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_we_n <= '1;
            r_oe_n <= '1;
            r_ce_n <= '1;
            r_doe  <= '0;
            r_addr <= '0;
            r_dout <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                r_ce_n[b] <= !(w_sel_wr[b] || w_sel_rd[b]);
                r_we_n[b] <= !(w_sel_wr[b] && w_wr_nxt == W_STROBE);
                r_oe_n[b] <= !w_sel_rd[b];
                r_doe[b]  <= w_sel_wr[b];
                r_addr[b] <= w_sel_wr[b] ? 16'(r_wr_ptr) : (w_sel_rd[b] ? 16'(r_rd_ptr) : 16'd0);
                r_dout[b] <= {8'h00, w_wbyte};
            end
        end
    end

    assign uart_out       = r_uart;
    assign sram_x_addr    = r_addr[0];
    assign sram_x_we_n    = r_we_n[0];
    assign sram_x_oe_n    = r_oe_n[0];
    assign sram_x_ce_a_n  = r_ce_n[0];
    assign sram_x_ub_a_n  = r_ce_n[0];
    assign sram_x_lb_a_n  = r_ce_n[0];
    assign sram_x_data_io = r_doe[0] ? r_dout[0] : 16'bz;
    assign sram_y_addr    = r_addr[1];
    assign sram_y_we_n    = r_we_n[1];
    assign sram_y_oe_n    = r_oe_n[1];
    assign sram_y_ce_a_n  = r_ce_n[1];
    assign sram_y_ub_a_n  = r_ce_n[1];
    assign sram_y_lb_a_n  = r_ce_n[1];
    assign sram_y_data_io = r_doe[1] ? r_dout[1] : 16'bz;
    assign sram_z_addr    = r_addr[2];
    assign sram_z_we_n    = r_we_n[2];
    assign sram_z_oe_n    = r_oe_n[2];
    assign sram_z_ce_a_n  = r_ce_n[2];
    assign sram_z_ub_a_n  = r_ce_n[2];
    assign sram_z_lb_a_n  = r_ce_n[2];
    assign sram_z_data_io = r_doe[2] ? r_dout[2] : 16'bz;
endmodule

// File: tb/tb_uart_triple_buffer_top.sv
// Directed bench: UART byte driver, SRAM models, write/TX monitors and table-driven checks.
module tb_uart_triple_buffer_top;
    localparam int CPB = 16;

    logic clk_in = 1'b0;
    logic button_reset, uart_in, tx_flow_control;
    logic uart_out;
    logic [15:0] x_addr, y_addr, z_addr;
    logic x_we_n, x_oe_n, x_ce_n, x_ub_n, x_lb_n;
    logic y_we_n, y_oe_n, y_ce_n, y_ub_n, y_lb_n;
    logic z_we_n, z_oe_n, z_ce_n, z_ub_n, z_lb_n;
    wire  [15:0] x_data, y_data, z_data;

    always #5 clk_in = ~clk_in;

    uart_triple_buffer_top #(.CLKS_PER_BIT(CPB), .BUF_DEPTH(16), .SRAM_WAIT(2)) dut (
        .clk_in(clk_in), .button_reset(button_reset), .uart_in(uart_in),
        .tx_flow_control(tx_flow_control), .uart_out(uart_out),
        .sram_x_addr(x_addr), .sram_x_we_n(x_we_n), .sram_x_oe_n(x_oe_n), .sram_x_ce_a_n(x_ce_n),
        .sram_x_ub_a_n(x_ub_n), .sram_x_lb_a_n(x_lb_n), .sram_x_data_io(x_data),
        .sram_y_addr(y_addr), .sram_y_we_n(y_we_n), .sram_y_oe_n(y_oe_n), .sram_y_ce_a_n(y_ce_n),
        .sram_y_ub_a_n(y_ub_n), .sram_y_lb_a_n(y_lb_n), .sram_y_data_io(y_data),
        .sram_z_addr(z_addr), .sram_z_we_n(z_we_n), .sram_z_oe_n(z_oe_n), .sram_z_ce_a_n(z_ce_n),
        .sram_z_ub_a_n(z_ub_n), .sram_z_lb_a_n(z_lb_n), .sram_z_data_io(z_data)
    );

    logic [2:0] we_v, oe_v, ce_v, ub_v, lb_v;
    logic [2:0][15:0] addr_v, data_v;
    assign we_v = {z_we_n, y_we_n, x_we_n};
    assign oe_v = {z_oe_n, y_oe_n, x_oe_n};
    assign ce_v = {z_ce_n, y_ce_n, x_ce_n};
    assign ub_v = {z_ub_n, y_ub_n, x_ub_n};
    assign lb_v = {z_lb_n, y_lb_n, x_lb_n};
    assign addr_v = {z_addr, y_addr, x_addr};
    assign data_v = {z_data, y_data, x_data};

    // Asynchronous SRAM models
    logic [15:0] mem [3][16];
    always @(posedge clk_in) begin
        for (int b = 0; b < 3; b++)
            if (!ce_v[b] && !we_v[b]) mem[b][addr_v[b][3:0]] <= data_v[b];
    end
    assign x_data = (!x_oe_n && !x_ce_n) ? mem[0][x_addr[3:0]] : 16'bz;
    assign y_data = (!y_oe_n && !y_ce_n) ? mem[1][y_addr[3:0]] : 16'bz;
    assign z_data = (!z_oe_n && !z_ce_n) ? mem[2][z_addr[3:0]] : 16'bz;

    typedef struct { int bank; logic [15:0] addr; logic [15:0] data; int low; } wr_t;
    wr_t        wq[$];
    logic [7:0] txq[$];
    int         lowcnt[3];
    int         oe_cnt[3];
    logic [2:0] oe_prev = 3'b111;
    int         act = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Write-cycle and read-strobe monitor
    always @(negedge clk_in) begin
        for (int b = 0; b < 3; b++) begin
            if (!button_reset) lowcnt[b] = 0;
            else if (!we_v[b]) lowcnt[b] = lowcnt[b] + 1;
            else if (lowcnt[b] != 0) begin
                wq.push_back('{b, addr_v[b], data_v[b], lowcnt[b]});
                lowcnt[b] = 0;
            end
            if (!oe_v[b] && oe_prev[b]) oe_cnt[b] = oe_cnt[b] + 1;
        end
        oe_prev = oe_v;
        if (ce_v != 3'b111) act = act + 1;
    end

    // Serial decoder for uart_out
    logic [7:0] mon_b;
    initial forever begin
        @(negedge clk_in);
        if (uart_out == 1'b0) begin
            repeat (CPB / 2) @(negedge clk_in);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk_in);
                mon_b[i] = uart_out;
            end
            repeat (CPB) @(negedge clk_in);
            txq.push_back(mon_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            uart_in = fr[i];
            repeat (CPB - 1) @(negedge clk_in);
        end
        @(negedge clk_in);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk_in);
    endtask

    task automatic do_reset();
        button_reset = 1'b0;
        repeat (3) @(negedge clk_in);
        button_reset = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic clear_mon();
        wq.delete();
        txq.delete();
        for (int b = 0; b < 3; b++) oe_cnt[b] = 0;
        act = 0;
    endtask

    task automatic wait_wq(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin @(negedge clk_in); k++; end
        check(name, wq.size(), n);
    endtask

    task automatic wait_txq(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin @(negedge clk_in); k++; end
        check(name, txq.size(), n);
    endtask

    task automatic wait_tx_low(input int budget, input string name);
        int k;
        k = 0;
        while (uart_out !== 1'b0 && k < budget) begin @(negedge clk_in); k++; end
        check(name, uart_out, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  din;
        int          exp_bank;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        int          exp_low;
        logic [7:0]  exp_tx;
    } vec_t;
    vec_t vt[16];

    initial begin
        for (int i = 0; i < 16; i++) vt[i] = '{8'(i), 0, 16'(i), 16'(i), 2, 8'(i)};
        uart_in = 1'b1;
        tx_flow_control = 1'b0;
        button_reset = 1'b0;
        repeat (4) @(negedge clk_in);

        // Reset state
        check("rst_uart_out", uart_out, 1'b1);
        check("rst_strobes", {we_v, oe_v, ce_v, ub_v, lb_v}, 15'h7fff);
        check("rst_x_addr", x_addr, 16'h0);
        check("rst_y_addr", y_addr, 16'h0);
        check("rst_z_addr", z_addr, 16'h0);
        button_reset = 1'b1;
        repeat (100) @(negedge clk_in);
        check("idle_sram_activity", act, 0);
        check("idle_writes", wq.size(), 0);

        // Fill one buffer: table-driven
        clear_mon();
        for (int i = 0; i < 16; i++) send_byte(vt[i].din, 1'b1);
        wait_wq(16, 200, "fill_write_count");
        for (int i = 0; i < 16 && i < wq.size(); i++) begin
            check($sformatf("fill_bank[%0d]", i), wq[i].bank, vt[i].exp_bank);
            check($sformatf("fill_addr[%0d]", i), wq[i].addr, vt[i].exp_addr);
            check($sformatf("fill_data[%0d]", i), wq[i].data, vt[i].exp_data);
            check($sformatf("fill_we_low[%0d]", i), wq[i].low, vt[i].exp_low);
        end
        wait_txq(16, 4000, "fill_tx_count");
        for (int i = 0; i < 16 && i < txq.size(); i++)
            check($sformatf("fill_tx[%0d]", i), txq[i], vt[i].exp_tx);
        check("fill_reads_x", oe_cnt[0], 16);
        check("fill_reads_yz", oe_cnt[1] + oe_cnt[2], 0);

        // Partial buffer is never transmitted
        do_reset();
        clear_mon();
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        wait_wq(5, 200, "partial_write_count");
        for (int i = 0; i < 5 && i < wq.size(); i++)
            check($sformatf("partial_addr[%0d]", i), wq[i].addr, 16'(i));
        repeat (2500) @(negedge clk_in);
        check("partial_tx_none", txq.size(), 0);
        check("partial_uart_idle", uart_out, 1'b1);

        // Flow control mid-transmission
        do_reset();
        clear_mon();
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b1);
        wait_txq(3, 2000, "flow_first3");
        wait_tx_low(500, "flow_byte4_start");
        repeat (CPB * 3) @(negedge clk_in);
        tx_flow_control = 1'b1;
        repeat (1500) @(negedge clk_in);
        check("flow_held_count", txq.size(), 4);
        check("flow_held_idle", uart_out, 1'b1);
        tx_flow_control = 1'b0;
        wait_txq(16, 3000, "flow_resume_count");
        repeat (400) @(negedge clk_in);
        check("flow_no_dup", txq.size(), 16);
        for (int i = 0; i < 16 && i < txq.size(); i++)
            check($sformatf("flow_tx[%0d]", i), txq[i], 8'h40 + 8'(i));

        // Overrun: B overwritten by C while A sits in READ
        do_reset();
        clear_mon();
        tx_flow_control = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b1);
        check("overrun_held", txq.size(), 0);
        tx_flow_control = 1'b0;
        wait_txq(32, 7000, "overrun_count");
        repeat (2000) @(negedge clk_in);
        check("overrun_total", txq.size(), 32);
        for (int i = 0; i < 32 && i < txq.size(); i++)
            check($sformatf("overrun_tx[%0d]", i), txq[i],
                  (i < 16) ? 8'h10 + 8'(i) : 8'h30 + 8'(i - 16));

        // Framing error: no write, then a good byte is accepted
        do_reset();
        clear_mon();
        send_byte(8'h5A, 1'b0);
        repeat (200) @(negedge clk_in);
        check("framing_no_write", wq.size(), 0);
        send_byte(8'h33, 1'b1);
        wait_wq(1, 200, "framing_recover_count");
        if (wq.size() > 0) check("framing_recover_data", wq[0].data, 16'h0033);

        // Reset mid-TX byte
        do_reset();
        clear_mon();
        for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), 1'b1);
        wait_tx_low(1000, "midop_tx_start");
        repeat (40) @(negedge clk_in);
        #2 button_reset = 1'b0;
        #1 check("midop_uart_high", uart_out, 1'b1);
        check("midop_strobes", {we_v, oe_v, ce_v, ub_v, lb_v}, 15'h7fff);
        repeat (5) @(negedge clk_in);
        button_reset = 1'b1;
        repeat (400) @(negedge clk_in);
        clear_mon();
        repeat (3000) @(negedge clk_in);
        check("midop_no_tx", txq.size(), 0);
        check("midop_no_activity", act, 0);

        // Roles after reset: x is WRITE and the buffer goes out from x
        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1);
        wait_wq(16, 200, "roles_write_count");
        for (int i = 0; i < 16 && i < wq.size(); i++)
            check($sformatf("roles_bank[%0d]", i), wq[i].bank, 0);
        wait_txq(16, 4000, "roles_tx_count");
        for (int i = 0; i < 16 && i < txq.size(); i++)
            check($sformatf("roles_tx[%0d]", i), txq[i], 8'h60 + 8'(i));
        check("roles_reads_x", oe_cnt[0], 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
